reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The module SHALL have these ports: clk  in  1  system clock; all state updates on the rising edge.
REQ-002 The module SHALL have these ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The module SHALL have these ports: rdy  in  1  global clock enable; no state change while low.
REQ-004 The module SHALL have these ports: rollback  in  1  flush of speculative state.
REQ-005 The module SHALL have these ports: decoder_done  in  1  issue strobe; the decoder is claiming a ROB entry this cycle.
REQ-006 The module SHALL have these ports: issue_rd  in  5  destination register of the issued instruction.
REQ-007 The module SHALL have these ports: issue_rob  in  4  ROB id allocated to the issued instruction.
REQ-008 The module SHALL have these ports: rs1_id / rs2_id  in  5  source register indices (two ports).
REQ-009 The module SHALL have these ports: rs1_value / rs2_value  out  32  architectural value.
REQ-010 The module SHALL have these ports: rs1_busy / rs2_busy  out  1  value pending in the ROB.
REQ-011 The module SHALL have these ports: rs1_rob_q / rs2_rob_q  out  4  ROB id producing the pending value.
REQ-012 The module SHALL have these ports: commit_reg_config, commit_reg_id[4:0], commit_reg_value[31:0], commit_reg_rob[3:0]  in  ROB register-commit bus.

Function
REQ-013 State SHALL be: 32 x 32-bit value, 32 x 1-bit busy and 32 x 4-bit tag arrays.
REQ-014 Register x0 SHALL always read value 0, busy 0 and tag 0, and is never written, tagged or made busy.
REQ-015 Read ports SHALL be combinational with zero-cycle latency.
REQ-016 Read bypass: when commit_reg_config=1, commit_reg_id equals rsN_id (nonzero), and the tag equals commit_reg_rob, rsN_value SHALL be commit_reg_value and rsN_busy SHALL be 0.
REQ-017 Read bypass: when commit_reg_config=1 and commit_reg_id equals rsN_id (nonzero) but the tag differs, rsN_value SHALL be commit_reg_value and busy/tag SHALL come from the arrays.
REQ-018 Commit (rdy=1, commit_reg_config=1, id≠0): value[id] SHALL be written; busy[id] SHALL be cleared only if tag[id]==commit_reg_rob; the tag SHALL be left unchanged.
REQ-019 Issue (rdy=1, decoder_done=1, issue_rd≠0, rollback=0): busy[issue_rd] SHALL be set to 1 and tag[issue_rd] to issue_rob.
REQ-020 Issue and commit to the same register in the same cycle: the value SHALL be written, busy SHALL be 1 and tag SHALL be issue_rob (issue wins).
REQ-021 Rollback (rdy=1): all busy bits SHALL be cleared and any issue in that cycle ignored; a commit in the same cycle SHALL still write its value.
REQ-022 Rollback SHALL NOT alter any value entries.
REQ-023 Priority SHALL be: rst_n low > rollback > issue/commit.
REQ-024 When rdy=0, all arrays SHALL hold; read ports SHALL still be driven.
REQ-025 The module SHALL accept one commit and one issue per cycle, with no backpressure.

Reset
REQ-026 While rst_n=0, all values, busy bits and tags SHALL be 0 immediately (asynchronous), so all read outputs are 0.
REQ-027 Reset asserted mid-operation SHALL discard pending tags; the first edge after release SHALL behave as a normal cycle.

Configuration
REQ-028 Macro REG_DEBUG_EN defined: an output reg_debugger [1023:0] SHALL be added, equal to {x31,...,x0} from the value array with no bypass, combinational.
REQ-029 Macro REG_DEBUG_EN undefined: the reg_debugger port and its logic SHALL be absent, with no other behavioural difference.

Verification
REQ-030 Reset scenario: hold rst_n=0, read rs1_id=5 -> value 0, busy 0, q 0; release -> unchanged.
REQ-031 Issue then commit: issue rd=3 rob=7; next cycle read x3 -> busy 1, q 7; commit id=3 rob=7 val=0x1234 -> same-cycle bypass value 0x1234, busy 0; next cycle array value 0x1234, busy 0.
REQ-032 Stale commit: issue rd=4 rob=2, then issue rd=4 rob=9, then commit id=4 rob=2 val=11 -> value 11, busy 1, q 9.
REQ-033 Simultaneous events: in one cycle issue rd=6 rob=1 and commit id=6 rob=0 val=42 while x6 has tag 0 -> after the edge value 42, busy 1, q 1.
REQ-034 Rollback: x1, x2 busy; rollback=1 with issue rd=8 and commit id=1 val=5 -> all busy 0, x8 not busy, x1=5.
REQ-035 x0 handling: issue rd=0 and commit id=0 val=99 -> x0 reads 0, busy 0; with rdy=0, commit id=7 val=3 -> x7 unchanged.

Source files
------------

// File: rtl/reg_file_if.sv
// Register file bus: issue strobe, two read ports and the ROB commit bus.
interface reg_file_if;
    logic        decoder_done;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_rob_q;
    logic [3:0]  rs2_rob_q;
    logic        commit_reg_config;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_reg_value;
    logic [3:0]  commit_reg_rob;

    modport master (
        output decoder_done, issue_rd, issue_rob,
        output rs1_id, rs2_id,
        input  rs1_value, rs2_value,
        input  rs1_busy, rs2_busy,
        input  rs1_rob_q, rs2_rob_q,
        output commit_reg_config, commit_reg_id,
        output commit_reg_value, commit_reg_rob
    );

    modport slave (
        input  decoder_done, issue_rd, issue_rob,
        input  rs1_id, rs2_id,
        output rs1_value, rs2_value,
        output rs1_busy, rs2_busy,
        output rs1_rob_q, rs2_rob_q,
        input  commit_reg_config, commit_reg_id,
        input  commit_reg_value, commit_reg_rob
    );
endinterface

// File: rtl/reg_file.sv
// Renamed register file: values, busy bits and ROB tags with commit bypass.
// Optional REG_DEBUG_EN exposes the raw value array on reg_debugger.
module reg_file (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy,
    input  logic           rollback,
    reg_file_if.slave      bus
`ifdef REG_DEBUG_EN
    ,
    output logic [1023:0]  reg_debugger
`endif
);

    logic [31:0] val_q  [32];
    logic        busy_q [32];
    logic [3:0]  tag_q  [32];

    logic cmt_en;
    logic iss_en;

    assign cmt_en = bus.commit_reg_config
                  && (bus.commit_reg_id != 5'd0);
    assign iss_en = bus.decoder_done && !rollback
                  && (bus.issue_rd != 5'd0);

    // Issue is applied after commit so it wins on a shared register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i]  <= 32'd0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= 4'd0;
            end
        end else if (rdy) begin
            if (cmt_en) begin
                val_q[bus.commit_reg_id] <= bus.commit_reg_value;
                if (tag_q[bus.commit_reg_id] == bus.commit_reg_rob)
                    busy_q[bus.commit_reg_id] <= 1'b0;
            end
            if (rollback) begin
                for (int i = 0; i < 32; i++)
                    busy_q[i] <= 1'b0;
            end else if (iss_en) begin
                busy_q[bus.issue_rd] <= 1'b1;
                tag_q[bus.issue_rd]  <= bus.issue_rob;
            end
        end
    end

    always_comb begin
        bus.rs1_value = val_q[bus.rs1_id];
        bus.rs1_busy  = busy_q[bus.rs1_id];
        bus.rs1_rob_q = tag_q[bus.rs1_id];
        if (bus.rs1_id == 5'd0) begin
            bus.rs1_value = 32'd0;
            bus.rs1_busy  = 1'b0;
            bus.rs1_rob_q = 4'd0;
        end else if (cmt_en
                     && bus.commit_reg_id == bus.rs1_id) begin
            bus.rs1_value = bus.commit_reg_value;
            if (tag_q[bus.rs1_id] == bus.commit_reg_rob)
                bus.rs1_busy = 1'b0;
        end
    end

    always_comb begin
        bus.rs2_value = val_q[bus.rs2_id];
        bus.rs2_busy  = busy_q[bus.rs2_id];
        bus.rs2_rob_q = tag_q[bus.rs2_id];
        if (bus.rs2_id == 5'd0) begin
            bus.rs2_value = 32'd0;
            bus.rs2_busy  = 1'b0;
            bus.rs2_rob_q = 4'd0;
        end else if (cmt_en
                     && bus.commit_reg_id == bus.rs2_id) begin
            bus.rs2_value = bus.commit_reg_value;
            if (tag_q[bus.rs2_id] == bus.commit_reg_rob)
                bus.rs2_busy = 1'b0;
        end
    end

`ifdef REG_DEBUG_EN
    for (genvar g = 0; g < 32; g++) begin : g_dbg
        assign reg_debugger[g*32 +: 32] = val_q[g];
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file against an array-based reference model.
// Directed cases cover reset, bypass, stale commit, rollback and x0.
module tb_reg_file;

    logic clk;
    logic rst_n;
    logic rdy;
    logic rollback;
    int   n_checks;
    int   n_fail;

    reg_file_if bus ();

`ifdef REG_DEBUG_EN
    logic [1023:0] reg_debugger;
`endif

    reg_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .rollback     (rollback),
        .bus          (bus)
`ifdef REG_DEBUG_EN
        ,
        .reg_debugger (reg_debugger)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state, mutated only at the modelled clock edge.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 0;
            m_busy[i] = 0;
            m_tag[i]  = 0;
        end
    endtask

    task automatic exp_rd(input logic [4:0] id,
                          output logic [31:0] v,
                          output logic b,
                          output logic [3:0] q);
        v = m_val[id];
        b = m_busy[id];
        q = m_tag[id];
        if (id == 0) begin
            v = 0;
            b = 0;
            q = 0;
        end else if (bus.commit_reg_config
                     && bus.commit_reg_id == id) begin
            v = bus.commit_reg_value;
            if (m_tag[id] == bus.commit_reg_rob) b = 0;
        end
    endtask

    task automatic check_reads();
        logic [31:0] v;
        logic        b;
        logic [3:0]  q;
        exp_rd(bus.rs1_id, v, b, q);
        check("rs1_value", bus.rs1_value, v);
        check("rs1_busy", {31'd0, bus.rs1_busy}, {31'd0, b});
        check("rs1_rob_q", {28'd0, bus.rs1_rob_q}, {28'd0, q});
        exp_rd(bus.rs2_id, v, b, q);
        check("rs2_value", bus.rs2_value, v);
        check("rs2_busy", {31'd0, bus.rs2_busy}, {31'd0, b});
        check("rs2_rob_q", {28'd0, bus.rs2_rob_q}, {28'd0, q});
`ifdef REG_DEBUG_EN
        for (int i = 0; i < 32; i++)
            check("dbg", reg_debugger[i*32 +: 32], m_val[i]);
`endif
    endtask

    // Model of one rising edge, sampled from the held inputs.
    task automatic m_edge();
        logic [4:0] cid;
        logic [4:0] rd;
        cid = bus.commit_reg_id;
        rd  = bus.issue_rd;
        if (!rst_n) begin
            m_clear();
        end else if (rdy) begin
            if (bus.commit_reg_config && cid != 0) begin
                m_val[cid] = bus.commit_reg_value;
                if (m_tag[cid] == bus.commit_reg_rob)
                    m_busy[cid] = 0;
            end
            if (rollback) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (bus.decoder_done && rd != 0) begin
                m_busy[rd] = 1;
                m_tag[rd]  = bus.issue_rob;
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_reads();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        rdy      = 1;
        rollback = 0;
        bus.decoder_done      = 0;
        bus.issue_rd          = 0;
        bus.issue_rob         = 0;
        bus.commit_reg_config = 0;
        bus.commit_reg_id     = 0;
        bus.commit_reg_value  = 0;
        bus.commit_reg_rob    = 0;
    endtask

    task automatic issue(input logic [4:0] rd,
                         input logic [3:0] rob);
        bus.decoder_done = 1;
        bus.issue_rd     = rd;
        bus.issue_rob    = rob;
    endtask

    task automatic commit(input logic [4:0] id,
                          input logic [31:0] val,
                          input logic [3:0] rob);
        bus.commit_reg_config = 1;
        bus.commit_reg_id     = id;
        bus.commit_reg_value  = val;
        bus.commit_reg_rob    = rob;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_clear();
        idle();
        rst_n = 0;
        bus.rs1_id = 5;
        bus.rs2_id = 0;
        #12;
        check("rst_val", bus.rs1_value, 0);
        check("rst_busy", {31'd0, bus.rs1_busy}, 0);
        check("rst_q", {28'd0, bus.rs1_rob_q}, 0);
        cycle();
        rst_n = 1;
        cycle();
        check("rel_val", bus.rs1_value, 0);

        // Issue, then same-cycle bypass of the matching commit.
        issue(3, 7);
        cycle();
        idle();
        bus.rs1_id = 3;
        #1;
        check("iss_busy", {31'd0, bus.rs1_busy}, 1);
        check("iss_q", {28'd0, bus.rs1_rob_q}, 7);
        commit(3, 32'h1234, 7);
        #1;
        check("byp_val", bus.rs1_value, 32'h1234);
        check("byp_busy", {31'd0, bus.rs1_busy}, 0);
        cycle();
        idle();
        #1;
        check("cmt_val", bus.rs1_value, 32'h1234);
        check("cmt_busy", {31'd0, bus.rs1_busy}, 0);

        // Stale commit keeps the newer rename.
        issue(4, 2);
        cycle();
        issue(4, 9);
        cycle();
        idle();
        commit(4, 11, 2);
        cycle();
        idle();
        bus.rs1_id = 4;
        #1;
        check("stale_val", bus.rs1_value, 11);
        check("stale_busy", {31'd0, bus.rs1_busy}, 1);
        check("stale_q", {28'd0, bus.rs1_rob_q}, 9);

        // Issue and commit to one register in one cycle.
        issue(6, 1);
        commit(6, 42, 0);
        cycle();
        idle();
        bus.rs1_id = 6;
        #1;
        check("sim_val", bus.rs1_value, 42);
        check("sim_busy", {31'd0, bus.rs1_busy}, 1);
        check("sim_q", {28'd0, bus.rs1_rob_q}, 1);

        // Rollback clears busy, drops issue, keeps commit.
        issue(1, 3);
        cycle();
        issue(2, 4);
        cycle();
        idle();
        rollback = 1;
        issue(8, 5);
        commit(1, 5, 0);
        cycle();
        idle();
        bus.rs1_id = 1;
        bus.rs2_id = 8;
        #1;
        check("rb_val", bus.rs1_value, 5);
        check("rb_busy1", {31'd0, bus.rs1_busy}, 0);
        check("rb_busy8", {31'd0, bus.rs2_busy}, 0);
        bus.rs2_id = 2;
        #1;
        check("rb_busy2", {31'd0, bus.rs2_busy}, 0);

        // x0 is immutable; rdy low freezes state.
        issue(0, 6);
        commit(0, 99, 0);
        cycle();
        idle();
        bus.rs1_id = 0;
        #1;
        check("x0_val", bus.rs1_value, 0);
        check("x0_busy", {31'd0, bus.rs1_busy}, 0);
        rdy = 0;
        commit(7, 3, 0);
        issue(7, 2);
        cycle();
        idle();
        bus.rs1_id = 7;
        #1;
        check("hold_val", bus.rs1_value, 0);
        check("hold_busy", {31'd0, bus.rs1_busy}, 0);

        // Random traffic with an async reset in the middle.
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [4:0] cid;
            idle();
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) != 0)
                issue($urandom_range(0, 31), $urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0) begin
                cid = $urandom_range(0, 31);
                r = $urandom_range(0, 1);
                commit(cid, $urandom,
                       (r != 0) ? m_tag[cid] : 4'($urandom));
            end
            bus.rs1_id = $urandom_range(0, 31);
            bus.rs2_id = ($urandom_range(0, 2) == 0)
                       ? bus.commit_reg_id
                       : 5'($urandom_range(0, 31));
            if (n == 200) begin
                idle();
                rst_n = 0;
                #1;
                m_clear();
                check_reads();
                @(posedge clk);
                #1;
                rst_n = 1;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
